// File: rtl/cpu_mem_responder_pkg.sv
// Shared constants for the CPU memory responder: MMIO map, error bit indices
// and TX_STATUS field layout.
package cpu_mem_responder_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // Byte offsets inside the MMIO window (only Address[3:2] is decoded)
    localparam logic [3:0] OFF_CYCLE     = 4'h0;
    localparam logic [3:0] OFF_TX_DATA   = 4'h4;
    localparam logic [3:0] OFF_TX_STATUS = 4'h8;
    localparam logic [3:0] OFF_ERR       = 4'hC;

    localparam int ERR_W        = 3;
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_ILLEGAL  = 1;
    localparam int ERR_OVERFLOW = 2;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_COUNT_LO = 4;
    localparam int ST_COUNT_W  = 4;

    function automatic logic [31:0] tx_status(input logic full,
                                              input logic empty,
                                              input logic [ST_COUNT_W-1:0] count);
        logic [31:0] s;
        s = '0;
        s[ST_FULL]                     = full;
        s[ST_EMPTY]                    = empty;
        s[ST_COUNT_LO +: ST_COUNT_W]   = count;
        return s;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU bus plus output-channel handshake between the core/harness and the responder.
interface cpu_mem_responder_if
    import cpu_mem_responder_pkg::*;
;
    logic [31:0]      Address;
    logic             MemRead;
    logic             MemWrite;
    logic [31:0]      Write_data;
    logic [31:0]      Read_data;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [ERR_W-1:0] err;

    modport master (
        output Address, MemRead, MemWrite, Write_data, out_ready,
        input  Read_data, out_data, out_valid, err
    );

    modport slave (
        input  Address, MemRead, MemWrite, Write_data, out_ready,
        output Read_data, out_data, out_valid, err
    );
endinterface

// File: rtl/cpu_mem_responder_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is reset so the head reads 0 straight after reset
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
        end
    end
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: combinational-read RAM, MMIO registers (cycle counter,
// TX channel, sticky errors) and an output FIFO drained by the harness.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    cpu_mem_responder_if.slave        bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      ram_mem [2**RAM_AW];
    logic [31:0]      cycle_reg;
    logic [ERR_W-1:0] err_reg;
    logic [ERR_W-1:0] err_next;
    logic [ERR_W-1:0] err_set;
    logic [ERR_W-1:0] err_clr;

    logic              is_mmio;
    logic [3:0]        reg_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              push_req;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       rdata;

    // Address[1:0] never reach the decode, so misaligned accesses act word-aligned
    assign is_mmio  = |(bus.Address & MMIO_BASE);
    assign reg_off  = {bus.Address[3:2], 2'b00};
    assign ram_idx  = bus.Address[RAM_AW+1:2];
    assign ram_we   = bus.MemWrite && !is_mmio && !rst;
    assign push_req = bus.MemWrite && is_mmio && (reg_off == OFF_TX_DATA);
    assign pop      = bus.out_valid && bus.out_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (bus.Write_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (bus.out_data)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.err       = err_reg;

    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_idx] <= bus.Write_data;
    end

    always_comb begin
        rdata = '0;
        if (bus.MemRead) begin
            if (!is_mmio) begin
                rdata = ram_mem[ram_idx];
            end else begin
                case (reg_off)
                    OFF_CYCLE:     rdata = cycle_reg;
                    OFF_TX_STATUS: rdata = tx_status(fifo_full, fifo_empty,
                                                     ST_COUNT_W'(fifo_count));
                    OFF_ERR:       rdata = 32'(err_reg);
                    default:       rdata = '0;
                endcase
            end
        end
    end
    assign bus.Read_data = rdata;

    // New error events override a same-cycle W1C clear
    always_comb begin
        err_set = '0;
        err_set[ERR_MISALIGN] = (bus.MemRead || bus.MemWrite) && (bus.Address[1:0] != 2'b00);
        err_set[ERR_ILLEGAL]  = is_mmio &&
            ((bus.MemWrite && ((reg_off == OFF_CYCLE) || (reg_off == OFF_TX_STATUS))) ||
             (bus.MemRead && (reg_off == OFF_TX_DATA)));
        err_set[ERR_OVERFLOW] = push_req && fifo_full && !pop;
        err_clr  = (bus.MemWrite && is_mmio && (reg_off == OFF_ERR)) ?
                   bus.Write_data[ERR_W-1:0] : '0;
        err_next = (err_reg & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_reg <= '0;
            err_reg   <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            err_reg   <= err_next;
        end
    end
endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the multi-cycle CPU bus: serves the CPU's Address/MemRead/MemWrite/Write_data requests and returns Read_data in the same cycle. It is built from three parts:
- a word-addressed RAM;
- a small memory-mapped I/O window: a free-running cycle counter, a buffered output channel and sticky error flags;
- an output FIFO that drains to the test harness through a valid/ready handshake.

It sits directly between the CPU core and the top level, and replaces ad-hoc bench memories.

## Interface
Parameters:
- RAM_AW, 8, RAM word-index width (2^RAM_AW words of 32 bits)
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- Address  in  32  byte address from CPU
- MemRead  in  1  read request (level, combinational response)
- MemWrite  in  1  write request, committed at rising clk edge
- Write_data  in  32  write data
- Read_data  out  32  read data, combinational
- out_data  out  32  FIFO head entry
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  harness accepts head this cycle
- err  out  3  sticky error flags: bit0 misaligned, bit1 illegal MMIO, bit2 FIFO overflow

## Operation
Address decode:
- Address[31]=0 → RAM. Word index is Address[RAM_AW+1:2]; bits above are ignored, so the RAM aliases.
- Address[31]=1 → MMIO, selected by Address[3:2]; Address[30:4] are ignored.
  - 0x8000_0000 CYCLE, RO: 32-bit counter.
  - 0x8000_0004 TX_DATA, WO: a write pushes Write_data into the FIFO; a read returns 0.
  - 0x8000_0008 TX_STATUS, RO: bit0 full, bit1 empty, bits[7:4] count, other bits 0.
  - 0x8000_000C ERR, RO/W1C: bits[2:0]=err. A write clears each bit whose Write_data bit is 1.

Reads:
- With MemRead=0, Read_data=0.
- With MemRead=1, Read_data is the decoded value of the current cycle, with no wait states.

Writes:
- RAM is written at the clk edge.
- RAM is not reset; the bench preloads it hierarchically.

Errors:
- Address[1:0]≠0 with MemRead or MemWrite: the access proceeds on the word-aligned address and err[0] is set.
- A write to CYCLE or TX_STATUS, or a read of TX_DATA, sets err[1]. Writes to read-only registers are otherwise ignored.
- A push while the FIFO is full is dropped unless a pop happens in the same cycle, and err[2] is set.
- A W1C write to ERR in the same cycle as a new error event: the set wins.

Simultaneous MemRead and MemWrite to the same location: Read_data shows the pre-write value and the write commits at the edge.

CYCLE counter:
- Increments every clk.
- Wraps from 0xFFFF_FFFF to 0.

FIFO:
- Push condition: MemWrite to TX_DATA and (not full, or pop in the same cycle).
- Pop condition: out_valid & out_ready.
- Push and pop together leave count unchanged, including when full.
- Pointers wrap modulo FIFO_DEPTH.
- out_data is the head storage entry. Its value is don't-care when out_valid=0, but it is 0 after reset.

## Timing
- Reset values: out_valid=0, out_data=0, err=0, CYCLE=0, FIFO count=0, all pointers 0.
- Read_data follows MemRead and Address, and is 0 while MemRead=0.
- Read latency is 0 cycles (combinational), as the CPU's fetch state requires.
- Write latency is 1 edge.
- A pushed entry appears on out_valid/out_data after the push edge.
- A pop takes effect at the edge where out_valid&out_ready=1; the next entry is visible in the following cycle.
- CYCLE read in cycle n returns n, counting edges since rst deassertion.
- Asserting rst mid-operation:
  - empties the FIFO and clears err and CYCLE immediately (asynchronous);
  - leaves RAM contents untouched;
  - drops an in-flight write.

## Structure
- Shared package holds:
  - the MMIO base and offsets (CYCLE, TX_DATA, TX_STATUS, ERR);
  - the err bit indices;
  - the TX_STATUS field positions.
- One sub-module: sync_fifo, parameterised by WIDTH and DEPTH, with ports push/pop/full/empty/count/head.
- Decode, RAM, counter and error logic stay in cpu_mem_responder.

## Test plan
- RAM round-trip:
  - write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → Read_data=0xDEADBEEF;
  - read 0x0000_0410 with RAM_AW=8 → same value (alias).
- Cycle counter:
  - read CYCLE 5 edges after reset → 5;
  - force the counter to 0xFFFF_FFFF → the next read returns 0.
- FIFO fill:
  - hold out_ready=0 and push 0x11, 0x22, 0x33, 0x44 → TX_STATUS=0x41 (count 4, full);
  - a 5th push of 0x55 is dropped and err=3'b100;
  - drain → out_data sequence 0x11, 0x22, 0x33, 0x44, then out_valid=0.
- FIFO concurrency:
  - with the FIFO full, push 0x66 while popping → count stays 4;
  - the new tail is 0x66 and err[2] is not set.
- Error flags:
  - read 0x0000_0006 → err[0] set and the word at 0x4 is returned;
  - write CYCLE → err[1] set;
  - write 0x2 to ERR → only err[1] cleared.
- Reset:
  - assert rst mid-drain with 2 entries queued → out_valid=0, err=0 and CYCLE=0 immediately;
  - RAM word at 0x10 is still 0xDEADBEEF after reset.
